// File: rtl/ready_table_ctrl_pkg.sv
// Shared types for the physical-register ready table controller.
// Entry layout of the write queue and controller state encoding.
package ready_table_ctrl_pkg;

    localparam int PREG_W = 6;
    localparam int NPREG  = 64;
    localparam int NRD    = 3;

    typedef logic [PREG_W-1:0] preg_t;

    typedef struct packed {
        preg_t preg;
        logic  val;
    } rdy_wq_entry_t;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } rtc_state_e;

endpackage

// File: rtl/ready_table_ctrl_qpram.sv
// 64x1 LUTRAM, one synchronous write port and three asynchronous reads.
// No reset: contents are established by the controller's sweep.
module qpram_64x1
    import ready_table_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  cen,
    input  logic                  wen,
    input  logic [PREG_W-1:0]     aw,
    input  logic                  di,
    input  logic [NRD*PREG_W-1:0] ar,
    output logic [NRD-1:0]        q
);

    logic [NPREG-1:0] mem;

    always_ff @(posedge clk) begin
        if (!cen && wen) begin
            mem[aw] <= di;
        end
    end

    always_comb begin
        q = '0;
        for (int p = 0; p < NRD; p++) begin
            q[p] = mem[ar[p*PREG_W +: PREG_W]];
        end
    end

endmodule

// File: rtl/ready_table_ctrl.sv
// Ready table controller: reset sweep, 3-to-1 write queue and
// read-side forwarding from pending queue entries.
module ready_table_ctrl
    import ready_table_ctrl_pkg::*;
#(
    parameter int QDEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,
    output logic                  req_ready,
    input  logic                  alloc_valid,
    input  logic [PREG_W-1:0]     alloc_preg,
    input  logic [1:0]            wake_valid,
    input  logic [2*PREG_W-1:0]   wake_preg,
    input  logic [NRD*PREG_W-1:0] rd_preg,
    output logic [NRD-1:0]        rd_ready
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    rtc_state_e state;
    rtc_state_e state_n;
    preg_t      sp;

    rdy_wq_entry_t wq [QDEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free_cnt;
    logic [CNT_W-1:0] nenq;

    logic          run;
    logic          deq;
    logic [2:0]    rv;
    rdy_wq_entry_t re [3];

    logic          ram_wen;
    preg_t         ram_aw;
    logic          ram_di;
    logic [NRD-1:0] ram_q;

    logic [NRD-1:0] fwd_hit;
    logic [NRD-1:0] fwd_val;
    logic [PTR_W-1:0] fidx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_INIT: if (sp == preg_t'(NPREG - 1)) state_n = ST_RUN;
            ST_RUN:  state_n = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (state == ST_INIT) begin
            sp <= sp + preg_t'(1);
        end
    end

    assign run       = (state == ST_RUN);
    assign init_done = run;
    assign free_cnt  = CNT_W'(QDEPTH) - count;
    assign req_ready = run && (free_cnt >= CNT_W'(3));
    assign deq       = run && (count != '0);

    // Slot order is age order: wake0 oldest, alloc youngest.
    always_comb begin
        re[0] = '{preg: wake_preg[0 +: PREG_W],      val: 1'b1};
        re[1] = '{preg: wake_preg[PREG_W +: PREG_W], val: 1'b1};
        re[2] = '{preg: alloc_preg,                  val: 1'b0};
        rv[0] = req_ready && wake_valid[0] && (re[0].preg != '0);
        rv[1] = req_ready && wake_valid[1] && (re[1].preg != '0);
        rv[2] = req_ready && alloc_valid   && (re[2].preg != '0);
        nenq  = CNT_W'(rv[0]) + CNT_W'(rv[1]) + CNT_W'(rv[2]);
    end

    always_ff @(posedge clk) begin
        if (rv[0]) begin
            wq[tail] <= re[0];
        end
        if (rv[1]) begin
            wq[tail + PTR_W'(rv[0])] <= re[1];
        end
        if (rv[2]) begin
            wq[tail + PTR_W'(rv[0]) + PTR_W'(rv[1])] <= re[2];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            tail  <= tail + PTR_W'(nenq);
            count <= count + nenq - CNT_W'(deq);
        end
    end

    assign ram_wen = !run || (count != '0);
    assign ram_aw  = run ? wq[head].preg : sp;
    assign ram_di  = run ? wq[head].val : 1'b1;

    qpram_64x1 u_ram (
        .clk (clk),
        .cen (1'b0),
        .wen (ram_wen),
        .aw  (ram_aw),
        .di  (ram_di),
        .ar  (rd_preg),
        .q   (ram_q)
    );

    // Walk oldest to youngest so the last match is the youngest.
    always_comb begin
        fwd_hit = '0;
        fwd_val = '0;
        fidx    = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int k = 0; k < QDEPTH; k++) begin
                fidx = head + PTR_W'(k);
                if ((CNT_W'(k) < count) &&
                    (wq[fidx].preg == rd_preg[p*PREG_W +: PREG_W])) begin
                    fwd_hit[p] = 1'b1;
                    fwd_val[p] = wq[fidx].val;
                end
            end
        end
    end

    always_comb begin
        rd_ready = '0;
        for (int p = 0; p < NRD; p++) begin
            if (!run) begin
                rd_ready[p] = 1'b0;
            end else if (rd_preg[p*PREG_W +: PREG_W] == '0) begin
                rd_ready[p] = 1'b1;
            end else if (fwd_hit[p]) begin
                rd_ready[p] = fwd_val[p];
            end else begin
                rd_ready[p] = ram_q[p];
            end
        end
    end

endmodule

// File: tb/tb_ready_table_ctrl.sv
// Directed bench for ready_table_ctrl: sweep, forwarding, conflicts,
// backpressure, preg 0 and mid-run reset.
module tb_ready_table_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_done;
    logic        req_ready;
    logic        alloc_valid;
    logic [5:0]  alloc_preg;
    logic [1:0]  wake_valid;
    logic [11:0] wake_preg;
    logic [17:0] rd_preg;
    logic [2:0]  rd_ready;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ready_table_ctrl #(.QDEPTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_done   (init_done),
        .req_ready   (req_ready),
        .alloc_valid (alloc_valid),
        .alloc_preg  (alloc_preg),
        .wake_valid  (wake_valid),
        .wake_preg   (wake_preg),
        .rd_preg     (rd_preg),
        .rd_ready    (rd_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        wake_valid  = 2'b00;
    endtask

    task automatic set_rd(input logic [5:0] a, input logic [5:0] b,
                          input logic [5:0] c);
        rd_preg = {c, b, a};
        #1;
    endtask

    // Requests must never be presented while the controller refuses them.
    always @(negedge clk) begin
        if (rst_n && (alloc_valid || (|wake_valid))) begin
            chk("proto_req_ready", req_ready, 1);
        end
    end

    task automatic wait_init(input string tag);
        set_rd(6'd0, 6'd0, 6'd0);
        chk({tag, "_rd_init"}, rd_ready, 3'b000);
        for (int c = 0; c < 64; c++) begin
            chk({tag, "_done_low"}, init_done, 0);
            chk({tag, "_rdy_low"}, req_ready, 0);
            tick();
        end
        chk({tag, "_done_c64"}, init_done, 1);
        chk({tag, "_rdy_c64"}, req_ready, 1);
    endtask

    initial begin
        rst_n   = 1'b0;
        rd_preg = '0;
        alloc_preg = '0;
        wake_preg  = '0;
        idle();
        repeat (3) tick();
        chk("rst_init_done", init_done, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rd_ready", rd_ready, 3'b000);
        chk("rst_count", dut.count, 0);

        rst_n = 1'b1;
        wait_init("init");
        for (int i = 0; i < 64; i++) begin
            set_rd(6'(i), 6'(63 - i), 6'((i + 21) % 64));
            chk("sweep_read", rd_ready, 3'b111);
            tick();
        end

        // alloc/wake round trip on preg 5
        alloc_valid = 1'b1;
        alloc_preg  = 6'd5;
        tick();
        idle();
        set_rd(6'd5, 6'd5, 6'd5);
        chk("rt_alloc_fwd", rd_ready, 3'b000);
        chk("rt_alloc_cnt", dut.count, 1);
        tick();
        chk("rt_alloc_ram", rd_ready, 3'b000);
        tick();
        wake_valid = 2'b01;
        wake_preg  = {6'd0, 6'd5};
        tick();
        idle();
        #1;
        chk("rt_wake_fwd", rd_ready, 3'b111);
        repeat (2) tick();
        chk("rt_wake_ram", rd_ready, 3'b111);
        chk("rt_wake_cnt", dut.count, 0);

        // alloc beats wake on the same preg
        alloc_valid = 1'b1;
        alloc_preg  = 6'd7;
        wake_valid  = 2'b01;
        wake_preg   = {6'd0, 6'd7};
        tick();
        idle();
        set_rd(6'd7, 6'd7, 6'd7);
        chk("cf_alloc_wins", rd_ready, 3'b000);
        repeat (3) tick();
        chk("cf_alloc_drain", rd_ready, 3'b000);

        alloc_valid = 1'b1;
        alloc_preg  = 6'd9;
        wake_valid  = 2'b11;
        wake_preg   = {6'd9, 6'd9};
        tick();
        idle();
        set_rd(6'd9, 6'd9, 6'd9);
        chk("cf_3way_alloc", rd_ready, 3'b000);
        wake_valid = 2'b11;
        wake_preg  = {6'd9, 6'd9};
        tick();
        idle();
        #1;
        chk("cf_wake_pair", rd_ready, 3'b111);
        repeat (5) tick();
        chk("cf_wake_drain", rd_ready, 3'b111);
        chk("cf_drain_cnt", dut.count, 0);

        // backpressure from an empty queue
        for (int j = 0; j < 3; j++) begin
            chk("bp_ready_on", req_ready, 1);
            alloc_valid = 1'b1;
            alloc_preg  = 6'(12 + 3 * j);
            wake_valid  = 2'b11;
            wake_preg   = {6'(11 + 3 * j), 6'(10 + 3 * j)};
            tick();
            chk("bp_count", dut.count, 3 + 2 * j);
        end
        idle();
        #1;
        chk("bp_ready_off7", req_ready, 0);
        set_rd(6'd12, 6'd10, 6'd16);
        chk("bp_fwd_mix", rd_ready, 3'b110);
        tick();
        chk("bp_count6", dut.count, 6);
        chk("bp_ready_off6", req_ready, 0);
        tick();
        chk("bp_count5", dut.count, 5);
        chk("bp_ready_back", req_ready, 1);
        repeat (6) tick();
        chk("bp_drained", dut.count, 0);
        set_rd(6'd12, 6'd15, 6'd18);
        chk("bp_ram_allocs", rd_ready, 3'b000);
        set_rd(6'd11, 6'd13, 6'd17);
        chk("bp_ram_wakes", rd_ready, 3'b111);

        // preg 0 is never enqueued
        alloc_valid = 1'b1;
        alloc_preg  = 6'd0;
        tick();
        idle();
        chk("p0_count", dut.count, 0);
        set_rd(6'd0, 6'd0, 6'd0);
        chk("p0_ready", rd_ready, 3'b111);

        // reset mid-run
        for (int j = 0; j < 4; j++) begin
            alloc_valid = 1'b1;
            alloc_preg  = 6'(20 + j);
            tick();
        end
        idle();
        chk("mr_count_pre", dut.count, 1);
        set_rd(6'd23, 6'd20, 6'd0);
        chk("mr_rd_pre", rd_ready, 3'b100);
        rst_n = 1'b0;
        tick();
        chk("mr_count", dut.count, 0);
        chk("mr_init_done", init_done, 0);
        chk("mr_req_ready", req_ready, 0);
        chk("mr_rd_ready", rd_ready, 3'b000);
        rst_n = 1'b1;
        wait_init("mr");
        set_rd(6'd20, 6'd21, 6'd22);
        chk("mr_swept_a", rd_ready, 3'b111);
        set_rd(6'd23, 6'd5, 6'd7);
        chk("mr_swept_b", rd_ready, 3'b111);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
